mem_arbiter: RTL
================

Name: mem_arbiter

Overview:
- Shares one single-port, fixed-latency unified memory between the fetch-stage instruction port (I, read-only) and the memory-stage data port (D, read/write).
- Serialises accesses with a 4-state FSM. D has fixed priority over I, with an anti-starvation override for I.
- Returns per-port data with a one-cycle ack pulse; the hazard unit stalls each stage on req & !ack.

Parameters:
AW, 32, address width (byte address, passed through unchanged)
DW, 32, data width
MEM_LAT, 2, cycles from mem_en to valid mem_rdata (legal 1..15)
STARVE_MAX, 4, consecutive D grants while i_req pending before I is forced (legal 1..15)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-high reset
i_req  in  1  fetch request, level, held until i_ack
i_addr  in  AW  fetch address
i_rdata  out  DW  fetch data, valid when i_ack, held afterwards
i_ack  out  1  one-cycle completion pulse for I
d_req  in  1  data request, level, held until d_ack
d_we  in  1  1 = store, 0 = load
d_addr  in  AW  data address
d_wdata  in  DW  store data
d_rdata  out  DW  load data, valid when d_ack, held afterwards
d_ack  out  1  one-cycle completion pulse for D
mem_en  out  1  memory access strobe, one cycle per transaction
mem_we  out  1  memory write enable, qualified by mem_en
mem_addr  out  AW  memory address
mem_wdata  out  DW  memory write data
mem_rdata  in  DW  memory read data, valid MEM_LAT cycles after mem_en

Behaviour:
- Reset (async, any state, including mid-transaction):
  - state = IDLE; cnt = 0; starve = 0.
  - All outputs 0, including i_rdata and d_rdata.
  - An in-flight transaction is abandoned with no ack.
- All outputs are registered. No combinational path from any input to any output.
- IDLE:
  - No request: stay in IDLE.
  - Grant rule: if d_req and !(i_req && starve == STARVE_MAX), grant D; else if i_req, grant I.
  - On grant: latch the owner; latch mem_addr, mem_we (d_we for D, 0 for I) and mem_wdata (d_wdata for D, 0 for I); go to ISSUE.
- ISSUE (1 cycle):
  - mem_en = 1.
  - cnt loaded with MEM_LAT-1.
  - Next state WAIT.
- WAIT (MEM_LAT cycles):
  - mem_en = 0; mem_addr, mem_we, mem_wdata held.
  - cnt decrements each cycle.
  - When cnt == 0: on a read, capture mem_rdata into the owner's rdata register; go to RESP.
- RESP (1 cycle):
  - Owner's ack = 1; next state IDLE.
  - Requests are not sampled in RESP, so the acked request, still high this cycle, is never re-granted.
- Timing: if a request is first seen in IDLE at cycle t, then mem_en is at t+1, data is sampled at t+1+MEM_LAT, and ack is at t+2+MEM_LAT. Minimum spacing between grants is MEM_LAT+3 cycles.
- Stores:
  - d_ack pulses with the same timing as loads.
  - d_rdata is not updated (keeps its last load value).
- Starvation counter:
  - starve increments (saturating at STARVE_MAX) on each D grant made while i_req = 1.
  - Cleared to 0 on every I grant.
  - Unchanged on a D grant with i_req = 0.
- Inputs are sampled only at grant. Changes to addr, wdata or we after the grant are ignored.
- Dropping req before ack is a protocol violation. The transaction still completes and acks; this is not checked in RTL.
- Simultaneous i_req and d_req in IDLE are resolved in one cycle; the loser keeps its req high and is served after the current RESP.
- mem_rdata is ignored outside the WAIT cnt == 0 cycle.
- i_ack and d_ack are never high in the same cycle.

Test Plan:
- Reset values: drive rst high mid-WAIT of a D load -> next cycle all outputs are 0, no d_ack follows, and state is IDLE. A new i_req after rst falls completes normally.
- Single I fetch (MEM_LAT=2): i_req=1, i_addr=0x10 seen at cycle 0 -> mem_en=1, mem_we=0, mem_addr=0x10 at cycle 1. Memory returns 0x8C01_0004 at cycle 3. i_ack=1 and i_rdata=0x8C01_0004 at cycle 4.
- D store then load to the same address: store d_addr=0x20, d_wdata=0xDEAD_BEEF -> mem_we=1 with mem_en, d_ack at cycle 4, d_rdata unchanged. The following load of 0x20 -> d_rdata=0xDEAD_BEEF on d_ack.
- Simultaneous requests: i_req=d_req=1 at cycle 0 -> D is granted (mem_addr=d_addr at cycle 1), d_ack at cycle 4. I is granted at the cycle-5 IDLE, with i_ack at cycle 9.
- Starvation (STARVE_MAX=2): d_req and i_req held high continuously -> grant order D, D, I, D, D, I. No cycle has both acks high.
- MEM_LAT=1 sweep: back-to-back I requests -> ack spacing is exactly 4 cycles. mem_en asserts exactly once per transaction.

Source files
------------

// File: rtl/mem_arbiter.sv
// Arbiter sharing one single-port, fixed-latency memory between the fetch (I) and data (D) ports.
// D has fixed priority; I is forced after STARVE_MAX consecutive D grants made while I waits.
module mem_arbiter #(
  parameter int AW         = 32,
  parameter int DW         = 32,
  parameter int MEM_LAT    = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_req,
  input  logic [AW-1:0] i_addr,
  output logic [DW-1:0] i_rdata,
  output logic          i_ack,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic [DW-1:0] d_rdata,
  output logic          d_ack,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  localparam logic [3:0] LAT_M1     = 4'(MEM_LAT - 1);
  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  state_t     state;
  logic       owner_d;
  logic [3:0] cnt;
  logic [3:0] starve;
  logic       grant_d;

  // D wins unless I has already been passed over STARVE_MAX times while waiting.
  assign grant_d = d_req && !(i_req && (starve == STARVE_LIM));

  // NOTE: every register below is assigned with <= so all updates in a cycle see pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      owner_d   <= 1'b0;
      cnt       <= '0;
      starve    <= '0;
      i_rdata   <= '0;
      i_ack     <= 1'b0;
      d_rdata   <= '0;
      d_ack     <= 1'b0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      i_ack <= 1'b0;
      d_ack <= 1'b0;
      case (state)
        IDLE: begin
          if (d_req || i_req) begin
            owner_d <= grant_d;
            mem_en  <= 1'b1;
            state   <= ISSUE;
            if (grant_d) begin
              mem_addr  <= d_addr;
              mem_we    <= d_we;
              mem_wdata <= d_wdata;
              if (i_req && (starve < STARVE_LIM)) starve <= starve + 4'd1;
            end else begin
              mem_addr  <= i_addr;
              mem_we    <= 1'b0;
              mem_wdata <= '0;
              starve    <= '0;
            end
          end
        end
        ISSUE: begin
          mem_en <= 1'b0;
          cnt    <= LAT_M1;
          state  <= WAIT;
        end
        WAIT: begin
          if (cnt == 4'd0) begin
            // Stores leave the owner's rdata untouched; only loads capture memory data.
            if (!mem_we) begin
              if (owner_d) d_rdata <= mem_rdata;
              else         i_rdata <= mem_rdata;
            end
            if (owner_d) d_ack <= 1'b1;
            else         i_ack <= 1'b1;
            state <= RESP;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        RESP: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
